// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory word loader (option: IMEM_LOADER_CHECKSUM_EN)
module imem_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CKSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_idx;
    logic [31:0] r_asm;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_error;
    logic        w_fire;
    logic        w_len_bad;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    assign w_fire    = in_valid && in_ready;
    assign w_len_bad = (in_data == 8'd0) || (32'(in_data) > 32'(DEPTH));
    assign mem_we    = r_we;
    assign mem_waddr = r_waddr;
    assign mem_wdata = r_wdata;
    assign error     = r_error;

    // In DATA a zero word count marks the final write cycle; no further bytes are taken then.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_fire) w_next = w_len_bad ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                busy     = 1'b1;
                in_ready = (r_cnt != 8'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (r_cnt == 8'd0) w_next = S_CKSUM;
`else
                if (r_cnt == 8'd0) w_next = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_fire) w_next = (in_data == r_sum) ? S_DONE : S_IDLE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_error <= 1'b0;
                end
                S_LEN: begin
                    if (w_fire) begin
                        if (w_len_bad) begin
                            r_error <= 1'b1;
                        end else begin
                            r_cnt  <= in_data;
                            r_addr <= '0;
                            r_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_sum  <= '0;
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_we    <= 1'b1;
                            r_wdata <= {in_data, r_asm[23:0]};
                            r_waddr <= r_addr;
                            r_addr  <= r_addr + 32'd1;
                            r_cnt   <= r_cnt - 8'd1;
                        end else begin
                            r_asm[8*r_idx +: 8] <= in_data;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CKSUM: begin
                    if (w_fire && (in_data != r_sum)) r_error <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
